powspec_frame_buffer: RTL and testbench

POWSPEC_FRAME_BUFFER -- requirements
Module: powspec_frame_buffer

---
 rtl/powspec_frame_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_powspec_frame_buffer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/powspec_frame_buffer.sv
// Ping-pong power-spectrum frame buffer: captures complete NBINS-bin frames from an
// unstoppable source and replays them in arrival order under valid/ready flow control.
module powspec_frame_buffer #(
  parameter int unsigned NBINS = 257,
  parameter int unsigned IDX_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tvalid_powspectr,
  input  logic [31:0]      powspectr,
  output logic             tvalid_bin,
  input  logic             tready_bin,
  output logic [31:0]      bin_data,
  output logic [IDX_W-1:0] bin_idx,
  output logic             tlast_bin,
  output logic             frame_overrun,
  output logic             short_frame,
  output logic [15:0]      frame_count
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS - 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  logic [DATA_W-1:0] r_mem0 [NBINS];
  logic [DATA_W-1:0] r_mem1 [NBINS];

  // writer state
  logic [IDX_W-1:0] r_wr_cnt;
  logic             r_wr_bank;
  logic             r_wr_drop;
  logic             r_overrun;
  logic             r_short;

  // bank bookkeeping
  logic [1:0]       r_full;
  logic             r_oldest;

  // reader state
  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rd_bank;
  logic             r_valid;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_wr_start;
  logic [1:0]       w_bank_free;
  logic             w_sel_bank;
  logic             w_none_free;
  logic             w_wr_bank;
  logic             w_wr_other;
  logic             w_wr_drop;
  logic             w_wr_last;
  logic             w_wr_en;
  logic [1:0]       w_fill_mask;
  logic [1:0]       w_rd_free_mask;
  logic [1:0]       w_full_nxt;
  logic             w_hs;
  logic             w_hs_last;
  logic             w_rd_other;
  logic             w_load;
  logic             w_load_bank;
  logic [IDX_W-1:0] w_load_idx;
  logic [DATA_W-1:0] w_rdata;

  assign w_hs           = r_valid & tready_bin;
  assign w_hs_last      = w_hs & r_last;
  assign w_rd_other     = ~r_rd_bank;
  assign w_rd_free_mask = w_hs_last ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  // A bank released by the reader this cycle is already usable by the writer.
  assign w_bank_free = ~r_full | w_rd_free_mask;
  assign w_sel_bank  = ~w_bank_free[0];
  assign w_none_free = ~|w_bank_free;

  assign w_wr_start  = tvalid_powspectr && (r_wr_cnt == '0);
  assign w_wr_bank   = w_wr_start ? w_sel_bank : r_wr_bank;
  assign w_wr_other  = ~w_wr_bank;
  assign w_wr_drop   = w_wr_start ? w_none_free : r_wr_drop;
  assign w_wr_last   = tvalid_powspectr && (r_wr_cnt == LAST_IDX);
  assign w_wr_en     = tvalid_powspectr && !w_wr_drop;
  assign w_fill_mask = (w_wr_en && w_wr_last) ? (w_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_full_nxt  = (r_full & ~w_rd_free_mask) | w_fill_mask;

  // Writer: frame counter, bank selection, drop/short detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_wr_drop <= 1'b0;
      r_overrun <= 1'b0;
      r_short   <= 1'b0;
    end else if (tvalid_powspectr) begin
      if (w_wr_start) begin
        r_wr_bank <= w_sel_bank;
        r_wr_drop <= w_none_free;
        if (w_none_free) r_overrun <= 1'b1;
      end
      r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + IDX_W'(1);
    end else if (r_wr_cnt != '0) begin
      r_wr_cnt <= '0;
      if (!r_wr_drop) r_short <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (w_wr_bank) r_mem1[r_wr_cnt] <= powspectr;
      else           r_mem0[r_wr_cnt] <= powspectr;
    end
  end

  // Full flags plus which full bank was filled first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= 2'b00;
      r_oldest <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (|w_fill_mask)
        r_oldest <= w_full_nxt[w_wr_other] ? w_wr_other : w_wr_bank;
      else if (|w_rd_free_mask)
        r_oldest <= w_rd_other;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Reader next state; chains straight into the other bank so back-to-back frames have no gap
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_bank = r_rd_bank;
    w_load_idx  = '0;
    case (r_state)
      S_IDLE: begin
        if (|r_full) begin
          w_state_nxt = S_READ;
          w_load      = 1'b1;
          w_load_bank = r_full[r_oldest] ? r_oldest : ~r_oldest;
        end
      end
      S_READ: begin
        if (w_hs) begin
          if (!r_last) begin
            w_load     = 1'b1;
            w_load_idx = r_idx + IDX_W'(1);
          end else if (r_full[w_rd_other]) begin
            w_load      = 1'b1;
            w_load_bank = w_rd_other;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rdata = w_load_bank ? r_mem1[w_load_idx] : r_mem0[w_load_idx];

  // Output register doubles as the RAM read register; holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_load) begin
        r_valid   <= 1'b1;
        r_data    <= w_rdata;
        r_idx     <= w_load_idx;
        r_last    <= (w_load_idx == LAST_IDX);
        r_rd_bank <= w_load_bank;
      end else if (w_hs) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      if (w_hs_last) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  assign tvalid_bin    = r_valid;
  assign bin_data      = r_data;
  assign bin_idx       = r_idx;
  assign tlast_bin     = r_last;
  assign frame_overrun = r_overrun;
  assign short_frame   = r_short;
  assign frame_count   = r_frame_cnt;

endmodule

// File: tb/tb_powspec_frame_buffer.sv
// Bench for powspec_frame_buffer: scoreboarded frame replay, flow control, drop/short
// handling, reset abort, and frame-counter wrap on a single-bin instance.
module tb_powspec_frame_buffer;
  localparam int unsigned NBINS = 257;
  localparam int unsigned IDX_W = 9;
  localparam int NWRAP = 65536 + 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, tvalid_powspectr, tready_bin;
  logic [31:0]      powspectr;
  logic             tvalid_bin, tlast_bin, frame_overrun, short_frame;
  logic [31:0]      bin_data;
  logic [IDX_W-1:0] bin_idx;
  logic [15:0]      frame_count;

  logic        rst2, tvalid2, tready2;
  logic [31:0] data2;
  logic        tvalid_bin2, tlast_bin2, overrun2, short2;
  logic [31:0] bin_data2;
  logic [0:0]  bin_idx2;
  logic [15:0] frame_count2;

  powspec_frame_buffer #(.NBINS(NBINS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .tvalid_powspectr(tvalid_powspectr), .powspectr(powspectr),
    .tvalid_bin(tvalid_bin), .tready_bin(tready_bin), .bin_data(bin_data), .bin_idx(bin_idx),
    .tlast_bin(tlast_bin), .frame_overrun(frame_overrun), .short_frame(short_frame),
    .frame_count(frame_count));

  powspec_frame_buffer #(.NBINS(1), .IDX_W(1)) dut2 (
    .clk(clk), .rst(rst2), .tvalid_powspectr(tvalid2), .powspectr(data2),
    .tvalid_bin(tvalid_bin2), .tready_bin(tready2), .bin_data(bin_data2), .bin_idx(bin_idx2),
    .tlast_bin(tlast_bin2), .frame_overrun(overrun2), .short_frame(short2),
    .frame_count(frame_count2));

  typedef struct {
    logic [31:0]      data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  typedef struct {
    int nvalid;
    int gap;
    bit emit;
    bit use_float;
    bit check;
    int exp_fc;
    bit exp_short;
    bit exp_ovr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ready_mode = 0;  // 0 high, 1 toggle, 2 low
  int   exp2 = 0;

  function automatic logic [31:0] int_to_f32(input int unsigned v);
    int unsigned p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 24; b++) if (v[b]) p = b;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: tready_bin = 1'b1;
      1: tready_bin = ~tready_bin;
      default: tready_bin = 1'b0;
    endcase
  end

  // Output monitor: scoreboard pop on handshake, hold check on stall
  logic        have_prev = 1'b0;
  logic [41:0] prev_out;
  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && tvalid_bin)
        check("stall_hold", 32'({bin_data[21:0], bin_idx, tlast_bin}), 32'(prev_out));
      have_prev = tvalid_bin && !tready_bin;
      prev_out  = {bin_data, bin_idx, tlast_bin};
      if (tvalid_bin && tready_bin) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got idx %0d data 0x%0h, required none", bin_idx, bin_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("bin_data", bin_data, e.data);
          check("bin_idx", 32'(bin_idx), 32'(e.idx));
          check("tlast_bin", 32'(tlast_bin), 32'(e.last));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst2 && tvalid_bin2 && tready2) begin
      check("wrap_data", bin_data2, 32'(exp2));
      exp2++;
    end
  end

  task automatic drive_frame(input int n, input bit emit, input bit use_float);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = use_float ? int_to_f32(i) : $urandom;
      tvalid_powspectr = 1'b1;
      powspectr = d;
      if (emit) sb.push_back('{d, IDX_W'(i), (i == int'(NBINS) - 1)});
      @(posedge clk); #1;
    end
    tvalid_powspectr = 1'b0;
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while ((sb.size() != 0 || tvalid_bin) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic main_seq();
    int cyc, lat;
    check("rst_tvalid", 32'(tvalid_bin), 0);
    check("rst_data", bin_data, 0);
    check("rst_idx", 32'(bin_idx), 0);
    check("rst_tlast", 32'(tlast_bin), 0);
    check("rst_overrun", 32'(frame_overrun), 0);
    check("rst_short", 32'(short_frame), 0);
    check("rst_fc", 32'(frame_count), 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      drive_frame(vecs[v].nvalid, vecs[v].emit, vecs[v].use_float);
      if (v == 0) begin
        lat = 0;
        while (!tvalid_bin && lat < 10) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat > 3) begin
          n_err++;
          $display("FAIL first_valid_latency: got %0d cycles, required <= 3", lat);
        end
        @(posedge clk); #1;
      end
      repeat (vecs[v].gap) begin @(posedge clk); #1; end
      if (vecs[v].check) begin
        wait_drain(cyc);
        check($sformatf("vec%0d_fc", v), 32'(frame_count), 32'(vecs[v].exp_fc));
        check($sformatf("vec%0d_short", v), 32'(short_frame), 32'(vecs[v].exp_short));
        check($sformatf("vec%0d_ovr", v), 32'(frame_overrun), 32'(vecs[v].exp_ovr));
      end
    end

    // ready toggling every cycle
    reset_dut();
    ready_mode = 1;
    drive_frame(NBINS, 1'b1, 1'b1);
    wait_drain(cyc);
    n_cmp++;
    if (cyc < 508 || cyc > 524) begin
      n_err++;
      $display("FAIL toggle_drain_cycles: got %0d, required 508..524", cyc);
    end
    check("toggle_fc", 32'(frame_count), 1);
    ready_mode = 0;

    // three frames into a stalled reader: third is dropped
    reset_dut();
    ready_mode = 2;
    drive_frame(NBINS, 1'b1, 1'b0);
    drive_frame(NBINS, 1'b1, 1'b0);
    drive_frame(NBINS, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("ovr_flag", 32'(frame_overrun), 1);
    check("ovr_fc_stalled", 32'(frame_count), 0);
    check("ovr_hold_valid", 32'(tvalid_bin), 1);
    check("ovr_hold_idx", 32'(bin_idx), 0);
    ready_mode = 0;
    wait_drain(cyc);
    check("ovr_fc", 32'(frame_count), 2);
    check("ovr_sticky", 32'(frame_overrun), 1);
    check("ovr_short", 32'(short_frame), 0);

    // reset while emitting bin 50, then a frame right after reset
    reset_dut();
    ready_mode = 2;
    drive_frame(NBINS, 1'b1, 1'b0);
    ready_mode = 0;
    cyc = 0;
    while (!(tvalid_bin && bin_idx == IDX_W'(50)) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("found_bin50", 32'(bin_idx), 50);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tvalid", 32'(tvalid_bin), 0);
    check("mid_rst_data", bin_data, 0);
    check("mid_rst_idx", 32'(bin_idx), 0);
    check("mid_rst_tlast", 32'(tlast_bin), 0);
    check("mid_rst_fc", 32'(frame_count), 0);
    sb.delete();
    rst = 1'b0;
    drive_frame(NBINS, 1'b1, 1'b0);
    wait_drain(cyc);
    check("post_rst_fc", 32'(frame_count), 1);
    check("post_rst_ovr", 32'(frame_overrun), 0);
  endtask

  task automatic wrap_seq();
    rst2 = 1'b0;
    for (int i = 0; i < NWRAP; i++) begin
      tvalid2 = 1'b1;
      data2 = 32'(i);
      @(posedge clk); #1;
    end
    tvalid2 = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("wrap_fc", 32'(frame_count2), 32'(NWRAP - 65536));
    check("wrap_ovr", 32'(overrun2), 0);
    check("wrap_short", 32'(short2), 0);
    check("wrap_count_out", 32'(exp2), 32'(NWRAP));
  endtask

  initial begin
    vecs[0] = '{257, 2, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0};
    vecs[1] = '{100, 5, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[2] = '{257, 0, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0};
    vecs[3] = '{256, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[4] = '{257, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[5] = '{257, 0, 1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b0};

    rst = 1'b1; tvalid_powspectr = 1'b0; powspectr = '0; tready_bin = 1'b1;
    rst2 = 1'b1; tvalid2 = 1'b0; data2 = '0; tready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fork
      main_seq();
      wrap_seq();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
